// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder with a valid strobe.
//
// Optional feature macro: FULL_ADDER_OVF_EN adds the ovf port and its register.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   sample a/b at this edge when high
//   a, b      in   WIDTH-bit unsigned operands
//   out       out  registered sum, a+b modulo 2^WIDTH
//   carry     out  registered carry-out of the MSB cell
//   out_valid out  high for one cycle per accepted operand pair
//   ovf       out  registered two's-complement overflow (FULL_ADDER_OVF_EN only)
module full_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             carry,
`ifdef FULL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_out_valid;

    // Ripple chain of 1-bit full-adder cells; bit 0 has no carry-in.
    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_sum[i]  = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    // Result registers: load on in_valid, otherwise hold; strobe is one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out   <= w_sum;
                r_carry <= w_c[WIDTH];
            end
        end
    end

    assign out       = r_out;
    assign carry     = r_carry;
    assign out_valid = r_out_valid;

`ifdef FULL_ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Overflow: operands share a sign and the sum's sign differs from it.
    assign w_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed-vector bench for full_adder (WIDTH=4).
module tb_full_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic       carry;
    logic       out_valid;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_checks;
    int n_fail;

    full_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .carry     (carry),
`ifdef FULL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       v;
        logic [3:0] e_out;
        logic       e_carry;
        logic       e_valid;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present operands at the falling edge, then sample just after the rising edge.
    task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tv);
        @(negedge clk);
        a        = ta;
        b        = tb;
        in_valid = tv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        //              a      b      v     out    carry  valid  ovf
        vecs[0]  = '{4'd9,  4'd5,  1'b1, 4'd14, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'd15, 4'd1,  1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
        vecs[2]  = '{4'd15, 4'd15, 1'b1, 4'd14, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'd0,  4'd0,  1'b1, 4'd0,  1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'd3,  4'd4,  1'b1, 4'd7,  1'b0, 1'b1, 1'b0};
        vecs[5]  = '{4'd15, 4'd15, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'd7,  4'd1,  1'b1, 4'd8,  1'b0, 1'b1, 1'b1};
        vecs[7]  = '{4'd1,  4'd1,  1'b0, 4'd8,  1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'd8,  4'd8,  1'b1, 4'd0,  1'b1, 1'b1, 1'b1};
        vecs[9]  = '{4'd7,  4'd8,  1'b1, 4'd15, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'd6,  4'd6,  1'b1, 4'd12, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{4'd10, 4'd3,  1'b0, 4'd12, 1'b0, 1'b0, 1'b1};

        // Reset state, including edges with in_valid high while in reset.
        #2;
        check("reset_out", 32'(out), 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        apply(4'd5, 4'd6, 1'b1);
        check("reset_ignore_out", 32'(out), 32'd0);
        check("reset_ignore_valid", 32'(out_valid), 32'd0);
`ifdef FULL_ADDER_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed table: wrap boundaries, hold, overflow cases.
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].v);
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].e_out));
            check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].e_carry));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
`ifdef FULL_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
`endif
        end

        // Exhaustive back-to-back sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                int exp_sum;
                exp_sum = ia + ib;
                apply(4'(ia), 4'(ib), 1'b1);
                check($sformatf("sweep_%0d_%0d_sum", ia, ib), 32'({carry, out}), 32'(exp_sum));
                check($sformatf("sweep_%0d_%0d_valid", ia, ib), 32'(out_valid), 32'd1);
`ifdef FULL_ADDER_OVF_EN
                begin
                    int sa;
                    int sb;
                    int ss;
                    sa = (ia > 7) ? ia - 16 : ia;
                    sb = (ib > 7) ? ib - 16 : ib;
                    ss = sa + sb;
                    check($sformatf("sweep_%0d_%0d_ovf", ia, ib), 32'(ovf),
                          (ss > 7 || ss < -8) ? 32'd1 : 32'd0);
                end
`endif
            end
        end

        // Async reset mid-stream.
        apply(4'd12, 4'd12, 1'b1);
        check("pre_reset_out", 32'(out), 32'd8);
        check("pre_reset_carry", 32'(carry), 32'd1);
        @(negedge clk);
        a        = 4'd5;
        b        = 4'd5;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_carry", 32'(carry), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_out", 32'(out), 32'd0);
        check("rst_hold_valid", 32'(out_valid), 32'd0);

        // First edge after release with in_valid high yields a result.
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd2, 4'd3, 1'b1);
        check("post_rst_out", 32'(out), 32'd5);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        apply(4'd2, 4'd3, 1'b0);
        check("post_rst_strobe_drop", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Registered 4-bit ripple-carry adder used as a basic arithmetic leaf cell in the combinational-logic datapath. It adds two unsigned 4-bit operands and produces a 4-bit sum and a carry-out. Results are captured in output registers on the rising clock edge, with a valid strobe so upstream logic can issue operands sparsely. An optional signed-overflow flag can be compiled in.

## Interface
- WIDTH, default 4: operand and sum width in bits; must be ≥ 1. All test values below assume 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on a/b are sampled when high at a rising edge.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out  output  WIDTH  registered sum, a+b modulo 2^WIDTH.
- carry  output  1  registered carry-out of the MSB stage.
- out_valid  output  1  high for one cycle per accepted operand pair.
- ovf  output  1  registered two's-complement overflow; present only with FULL_ADDER_OVF_EN.

## Operation
- Sum is built as a chain of WIDTH 1-bit full-adder cells. Bit 0 has carry-in 0.
- Each cell: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)).
- carry = c_WIDTH, so {carry, out} = a + b exactly, with a 5-bit result range of 0..30 for WIDTH=4.
- No saturation. Wrap-around is the only behaviour: 15+1 gives out=0 and carry=1.
- in_valid high at an edge: out, carry (and ovf) load the new result; out_valid is set to 1.
- in_valid low at an edge: out, carry and ovf hold their previous values; out_valid is set to 0.
- Operand changes between edges have no effect on outputs; there is no combinational path from inputs to outputs.
- ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on out/carry/out_valid immediately after edge N.
- Throughput is one operation per cycle. Back-to-back in_valid is fully supported with no bubbles.
- Reset values: out=0, carry=0, out_valid=0, ovf=0.
- rst_n low forces the reset values immediately, independent of clk. While rst_n is low, in_valid is ignored.
- Reset asserted mid-stream discards the in-flight result. The first edge with rst_n high and in_valid high produces a valid result on that edge.
- rst_n deassertion is synchronised to clk externally. The block has no internal synchroniser.
- No backpressure exists: out_valid is not held, and the consumer must capture it in the cycle it is high.

## Configuration
- FULL_ADDER_OVF_EN defined: the ovf port and its register exist and follow the rule above, with updates and holds identical to out.
- FULL_ADDER_OVF_EN undefined: no ovf port and no overflow logic. All other behaviour is identical.

## Test plan
- Exhaustive sweep: a=0..15 (outer loop) × b=0..15 (inner loop), in_valid=1 every cycle. Each cycle, {carry,out} equals the previous cycle's a+b (e.g. a=9, b=5 gives out=14, carry=0), and out_valid stays 1.
- Wrap boundaries: a=15, b=1 gives out=0, carry=1; a=15, b=15 gives out=14, carry=1; a=0, b=0 gives out=0, carry=0.
- Hold: apply a=3, b=4 with in_valid=1, then a=15, b=15 with in_valid=0. out stays 7, carry stays 0, and out_valid drops to 0 on the second edge.
- Async reset mid-stream: after a=12, b=12 (out=8, carry=1), pull rst_n low between edges. out=0, carry=0 and out_valid=0 take effect immediately, without a clock edge, and hold for as long as reset is low.
- Overflow (FULL_ADDER_OVF_EN): a=7, b=1 gives ovf=1, out=8; a=8, b=8 gives ovf=1, carry=1, out=0; a=7, b=8 gives ovf=0.
